// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave that frames 10-bit commands for a RAM and returns read bytes on MISO
module spi_slave_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;
  state_t state, next_state;
  logic [3:0] bit_cnt;
  logic [8:0] shift_reg;
  logic       rd_addr_flag;
  logic       tx_done;
  logic [6:0] tx_shift;
  logic [2:0] tx_cnt;
  logic       in_frame;
  logic       abort;
  logic       frame_last;
  logic       tx_start;
  assign in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign abort      = SS_n && (state != IDLE);
  assign frame_last = in_frame && (bit_cnt == 4'd8);
  assign tx_start   = (state == READ_DATA) && (bit_cnt == 4'd9) && tx_valid && !tx_done;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end
  // next state: SS_n high returns any active state to IDLE; the command bit picks the frame type
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = SS_n ? IDLE : CHK_CMD;
      CHK_CMD: next_state = SS_n ? IDLE : !MOSI ? WRITE : rd_addr_flag ? READ_DATA : READ_ADD;
      default: next_state = SS_n ? IDLE : state;
    endcase
  end
  // frame shifting, rx strobe, read-address flag and MISO byte serializer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= 4'd0;
      shift_reg    <= 9'd0;
      rx_data      <= 10'd0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_done      <= 1'b0;
      tx_shift     <= 7'd0;
      tx_cnt       <= 3'd0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        bit_cnt   <= 4'd0;
        shift_reg <= 9'd0;
        tx_done   <= 1'b0;
        tx_shift  <= 7'd0;
        tx_cnt    <= 3'd0;
        MISO      <= 1'b0;
      end else begin
        if (state == CHK_CMD) shift_reg <= {8'd0, MOSI};
        if (in_frame && bit_cnt < 4'd9) begin
          shift_reg <= {shift_reg[7:0], MOSI};
          bit_cnt   <= bit_cnt + 4'd1;
        end
        if (frame_last) begin
          rx_data  <= {shift_reg, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD)  rd_addr_flag <= 1'b1;
          if (state == READ_DATA) rd_addr_flag <= 1'b0;
        end
        if (tx_start) begin
          MISO     <= tx_data[7];
          tx_shift <= tx_data[6:0];
          tx_cnt   <= 3'd7;
          tx_done  <= 1'b1;
        end else if (tx_cnt != 3'd0) begin
          MISO     <= tx_shift[6];
          tx_shift <= {tx_shift[5:0], 1'b0};
          tx_cnt   <= tx_cnt - 3'd1;
        end else begin
          MISO <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed self-checking bench for spi_slave_ctrl
module tb_spi_slave_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  localparam logic [2:0] S_IDLE = 3'd0, S_WRITE = 3'd2, S_RADD = 3'd3, S_RDATA = 3'd4;
  spi_slave_ctrl dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rx_valid) pulses++;
  task automatic send(input logic [9:0] f, input int n);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MOSI = f[9-i];
    end
    @(posedge clk);
    #1;
  endtask
  task automatic end_frame();
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (MISO !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b want 0", MISO); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL reset_rx_data got %h want 000", rx_data); end
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dut.state, S_IDLE); end
    n_cmp++; if (dut.rd_addr_flag !== 1'b0) begin n_err++; $display("FAIL reset_flag got %b want 0", dut.rd_addr_flag); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_write_addr();
    int p0;
    p0 = pulses;
    send(10'h055, 10);
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL wa_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 10'h055) begin n_err++; $display("FAIL wa_data got %h want 055", rx_data); end
    n_cmp++; if (dut.state !== S_WRITE) begin n_err++; $display("FAIL wa_state got %0d want %0d", dut.state, S_WRITE); end
    repeat (3) begin
      @(negedge clk);
      MOSI = ~MOSI;
    end
    @(posedge clk);
    #1;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL wa_valid_drop got %b want 0", rx_valid); end
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL wa_pulses got %0d want 1", pulses - p0); end
    n_cmp++; if (rx_data !== 10'h055) begin n_err++; $display("FAIL wa_hold got %h want 055", rx_data); end
    n_cmp++; if (dut.state !== S_WRITE) begin n_err++; $display("FAIL wa_stay got %0d want %0d", dut.state, S_WRITE); end
    end_frame();
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL wa_idle got %0d want %0d", dut.state, S_IDLE); end
  endtask
  task automatic test_write_data();
    send(10'h1AA, 10);
    n_cmp++; if (rx_data !== 10'h1AA) begin n_err++; $display("FAIL wd_data got %h want 1AA", rx_data); end
    n_cmp++; if (dut.rd_addr_flag !== 1'b0) begin n_err++; $display("FAIL wd_flag got %b want 0", dut.rd_addr_flag); end
    end_frame();
  endtask
  task automatic test_read();
    logic [7:0] got;
    send(10'h205, 10);
    n_cmp++; if (rx_data !== 10'h205) begin n_err++; $display("FAIL ra_data got %h want 205", rx_data); end
    n_cmp++; if (dut.state !== S_RADD) begin n_err++; $display("FAIL ra_state got %0d want %0d", dut.state, S_RADD); end
    n_cmp++; if (dut.rd_addr_flag !== 1'b1) begin n_err++; $display("FAIL ra_flag got %b want 1", dut.rd_addr_flag); end
    end_frame();
    send(10'h3A5, 10);
    n_cmp++; if (dut.state !== S_RDATA) begin n_err++; $display("FAIL rd_state got %0d want %0d", dut.state, S_RDATA); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 10'h3A5) begin n_err++; $display("FAIL rd_data got %h want 3A5", rx_data); end
    n_cmp++; if (dut.rd_addr_flag !== 1'b0) begin n_err++; $display("FAIL rd_flag got %b want 0", dut.rd_addr_flag); end
    n_cmp++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_miso_idle got %b want 0", MISO); end
    @(negedge clk);
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    got[7] = MISO;
    tx_valid = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      @(posedge clk);
      #1;
      got[i] = MISO;
    end
    n_cmp++; if (got !== 8'hC3) begin n_err++; $display("FAIL rd_miso_byte got %h want C3", got); end
    @(posedge clk);
    #1;
    n_cmp++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_miso_after got %b want 0", MISO); end
    @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    n_cmp++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_second_valid got %b want 0", MISO); end
    n_cmp++; if (dut.state !== S_RDATA) begin n_err++; $display("FAIL rd_stay got %0d want %0d", dut.state, S_RDATA); end
    end_frame();
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL rd_idle got %0d want %0d", dut.state, S_IDLE); end
  endtask
  task automatic test_abort();
    int p0;
    send(10'h2F0, 10);
    end_frame();
    p0 = pulses;
    send(10'h1FF, 5);
    end_frame();
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL ab_state got %0d want %0d", dut.state, S_IDLE); end
    n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL ab_pulses got %0d want %0d", pulses, p0); end
    n_cmp++; if (rx_data !== 10'h2F0) begin n_err++; $display("FAIL ab_hold got %h want 2F0", rx_data); end
    n_cmp++; if (dut.rd_addr_flag !== 1'b1) begin n_err++; $display("FAIL ab_flag got %b want 1", dut.rd_addr_flag); end
    send(10'h0F0, 10);
    n_cmp++; if (rx_data !== 10'h0F0) begin n_err++; $display("FAIL ab_next_data got %h want 0F0", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ab_next_valid got %b want 1", rx_valid); end
    n_cmp++; if (dut.state !== S_WRITE) begin n_err++; $display("FAIL ab_next_state got %0d want %0d", dut.state, S_WRITE); end
    end_frame();
  endtask
  task automatic test_ss_priority();
    int p0;
    p0 = pulses;
    send(10'h0AB, 9);
    @(negedge clk);
    MOSI = 1'b1;
    SS_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL pri_state got %0d want %0d", dut.state, S_IDLE); end
    @(posedge clk);
    #1;
    n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL pri_pulses got %0d want %0d", pulses, p0); end
    n_cmp++; if (rx_data !== 10'h0F0) begin n_err++; $display("FAIL pri_hold got %h want 0F0", rx_data); end
  endtask
  task automatic test_sticky();
    logic [7:0] got;
    int ones;
    send(10'h300, 10);
    n_cmp++; if (dut.state !== S_RDATA) begin n_err++; $display("FAIL st_state got %0d want %0d", dut.state, S_RDATA); end
    @(negedge clk);
    tx_data = 8'h96;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    got[7] = MISO;
    for (int i = 6; i >= 0; i--) begin
      @(posedge clk);
      #1;
      got[i] = MISO;
    end
    ones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (MISO) ones++;
    end
    tx_valid = 1'b0;
    n_cmp++; if (got !== 8'h96) begin n_err++; $display("FAIL st_byte got %h want 96", got); end
    n_cmp++; if (ones !== 0) begin n_err++; $display("FAIL st_extra_bits got %0d want 0", ones); end
    end_frame();
  endtask
  task automatic test_reset_mid();
    int p0;
    send(10'h2AA, 10);
    end_frame();
    send(10'h355, 10);
    @(negedge clk);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    n_cmp++; if (MISO !== 1'b1) begin n_err++; $display("FAIL rm_bit3 got %b want 1", MISO); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rm_miso got %b want 0", MISO); end
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL rm_state got %0d want %0d", dut.state, S_IDLE); end
    n_cmp++; if (dut.rd_addr_flag !== 1'b0) begin n_err++; $display("FAIL rm_flag got %b want 0", dut.rd_addr_flag); end
    @(negedge clk);
    rst = 1'b0;
    SS_n = 1'b1;
    send(10'h2AA, 10);
    end_frame();
    n_cmp++; if (dut.rd_addr_flag !== 1'b1) begin n_err++; $display("FAIL rf_pre_flag got %b want 1", dut.rd_addr_flag); end
    p0 = pulses;
    send(10'h1FF, 6);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (dut.rd_addr_flag !== 1'b0) begin n_err++; $display("FAIL rf_flag got %b want 0", dut.rd_addr_flag); end
    n_cmp++; if (dut.state !== S_IDLE) begin n_err++; $display("FAIL rf_state got %0d want %0d", dut.state, S_IDLE); end
    n_cmp++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL rf_data got %h want 000", rx_data); end
    @(negedge clk);
    rst = 1'b0;
    SS_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL rf_pulses got %0d want %0d", pulses, p0); end
  endtask
  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read();
    test_abort();
    test_ss_priority();
    test_sticky();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
